// File: rtl/mkio_tx_sched.sv
// mkio_tx_sched: MKIO remote-terminal transmit scheduler (status word, then DEV4 data words)
module mkio_tx_sched #(
  parameter int GAP_CYCLES = 128,
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic          cmd_tr,
  input  logic [4:0]    cmd_wc,
  input  logic [4:0]    rt_addr,
  input  logic [10:0]   status_bits,
  input  logic          abort,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          enc_start,
  output logic          enc_sync,
  output logic [DW-1:0] enc_data,
  input  logic          enc_busy,
  output logic          busy,
  output logic          done
);
  localparam int GW = $clog2(GAP_CYCLES);
  typedef enum logic [2:0] {IDLE, GAP, STAT, STAT_WAIT, FETCH, DATA, DATA_WAIT, FIN} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] gap_q;
  logic [5:0] cnt_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] data_q, enc_data_q, stat_q;
  logic tr_q, seen_q, rd_q, have_q, need, fall, waiting;
  assign waiting = state_q == STAT_WAIT || state_q == DATA_WAIT;
  assign need = state_q == STAT_WAIT ? tr_q : cnt_q != 6'd0;
  assign fall = seen_q && !enc_busy;
  assign enc_start = state_q == STAT || state_q == DATA;
  assign enc_sync = state_q == STAT;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign mem_addr = mem_addr_q;
  assign enc_data = enc_data_q;
  // Next state and read strobe; prefetch fires on the first busy cycle of each word.
  always_comb begin
    state_d = state_q;
    mem_rd = 1'b0;
    case (state_q)
      IDLE:      state_d = cmd_valid && !abort ? GAP : IDLE;
      GAP:       state_d = gap_q == GW'(GAP_CYCLES - 2) ? STAT : GAP;
      STAT:      state_d = STAT_WAIT;
      STAT_WAIT,
      DATA_WAIT: begin
        mem_rd = enc_busy && !seen_q && need;
        state_d = !fall ? state_q : !need ? FIN : (have_q || rd_q) ? DATA : FETCH;
      end
      FETCH: begin
        mem_rd = !rd_q;
        state_d = rd_q ? DATA : FETCH;
      end
      DATA:      state_d = DATA_WAIT;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end
  // Sequence registers: command latch, gap timer, prefetch buffer, word counter and address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gap_q <= '0;
      cnt_q <= '0;
      mem_addr_q <= '0;
      data_q <= '0;
      enc_data_q <= '0;
      stat_q <= '0;
      tr_q <= 1'b0;
      seen_q <= 1'b0;
      rd_q <= 1'b0;
      have_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q <= state_q == GAP ? gap_q + 1'b1 : '0;
      seen_q <= waiting && (seen_q || enc_busy);
      rd_q <= mem_rd;
      have_q <= rd_q || (have_q && state_q != DATA && state_q != IDLE);
      if (rd_q) data_q <= mem_data;
      if (state_q == IDLE && state_d == GAP) begin
        tr_q <= cmd_tr;
        cnt_q <= {cmd_wc == 5'd0, cmd_wc};
        stat_q <= DW'({rt_addr, status_bits});
        mem_addr_q <= '0;
      end
      if (state_d == STAT) enc_data_q <= stat_q;
      if (state_d == DATA) enc_data_q <= rd_q ? mem_data : data_q;
      if (state_q == DATA) begin
        cnt_q <= cnt_q - 1'b1;
        mem_addr_q <= mem_addr_q + 1'b1;
      end
    end
  end
endmodule
